// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU: FSM states, C-instruction
// field positions, destination bits and jump codes.
package hack_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MRD   = 2'd2,
    S_MWR   = 2'd3
  } state_e;

  localparam int C_A_BIT   = 12;
  localparam int C_CMP_HI  = 11;
  localparam int C_CMP_LO  = 6;
  localparam int C_DEST_HI = 5;
  localparam int C_DEST_LO = 3;
  localparam int C_JMP_HI  = 2;
  localparam int C_JMP_LO  = 0;

  // Bit positions inside the 3-bit destination field (A,D,M ordering).
  localparam int DEST_M = 0;
  localparam int DEST_D = 1;
  localparam int DEST_A = 2;

  localparam logic [2:0] J_NULL = 3'b000;
  localparam logic [2:0] J_JGT  = 3'b001;
  localparam logic [2:0] J_JEQ  = 3'b010;
  localparam logic [2:0] J_JGE  = 3'b011;
  localparam logic [2:0] J_JLT  = 3'b100;
  localparam logic [2:0] J_JNE  = 3'b101;
  localparam logic [2:0] J_JLE  = 3'b110;
  localparam logic [2:0] J_JMP  = 3'b111;

  // zx is the MSB so a slice of the instruction casts directly.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: x is D, y is A or M; produces result plus zero and
// negative flags at DATA_W bits.
module hack_alu
  import hack_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  alu_ctrl_t         ctrl_i,
  output logic [DATA_W-1:0] out_o,
  output logic              zr_o,
  output logic              ng_o
);

  logic [DATA_W-1:0] xz, xn, yz, yn, fo, res;

  always_comb begin
    xz    = ctrl_i.zx ? '0 : x_i;
    xn    = ctrl_i.nx ? ~xz : xz;
    yz    = ctrl_i.zy ? '0 : y_i;
    yn    = ctrl_i.ny ? ~yz : yz;
    fo    = ctrl_i.f ? (xn + yn) : (xn & yn);
    res   = ctrl_i.no ? ~fo : fo;
    out_o = res;
    zr_o  = (res == '0);
    ng_o  = res[DATA_W-1];
  end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH/EXEC/MRD/MWR state machine with handshaked
// instruction and data memories, one retire pulse per completed instruction.
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] d_reg,
  output logic              retire
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] areg_q, areg_d;
  logic [DATA_W-1:0] dreg_q, dreg_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ireq_q, ireq_d;
  logic              dreq_q, dreq_d;
  logic              dwe_q, dwe_d;
  logic              retire_q, retire_d;

  logic              is_c, use_m, commit, jump;
  logic [2:0]        dest, jcode;
  logic [DATA_W-1:0] alu_y, alu_out;
  logic              alu_zr, alu_ng;

  assign is_c  = ir_q[DATA_W-1];
  assign use_m = ir_q[C_A_BIT];
  assign dest  = ir_q[C_DEST_HI:C_DEST_LO];
  assign jcode = ir_q[C_JMP_HI:C_JMP_LO];

  // In MRD the memory word replaces A as the y operand.
  assign alu_y = (state_q == S_MRD) ? dmem_rdata : areg_q;

  hack_alu #(.DATA_W(DATA_W)) u_alu (
    .x_i    (dreg_q),
    .y_i    (alu_y),
    .ctrl_i (alu_ctrl_t'(ir_q[C_CMP_HI:C_CMP_LO])),
    .out_o  (alu_out),
    .zr_o   (alu_zr),
    .ng_o   (alu_ng)
  );

  always_comb begin
    jump = 1'b0;
    unique case (jcode)
      J_NULL: jump = 1'b0;
      J_JGT:  jump = ~alu_ng & ~alu_zr;
      J_JEQ:  jump = alu_zr;
      J_JGE:  jump = ~alu_ng;
      J_JLT:  jump = alu_ng;
      J_JNE:  jump = ~alu_zr;
      J_JLE:  jump = alu_ng | alu_zr;
      J_JMP:  jump = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    areg_d   = areg_q;
    dreg_d   = dreg_q;
    ir_d     = ir_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    retire_d = 1'b0;
    commit   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (ireq_q && imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!is_c) begin
          areg_d   = {1'b0, ir_q[DATA_W-2:0]};
          pc_d     = pc_q + PC_ONE;
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end else if (use_m) begin
          state_d = S_MRD;
        end else begin
          commit = 1'b1;
        end
      end
      S_MRD: begin
        if (dmem_ack) commit = 1'b1;
      end
      S_MWR: begin
        if (dmem_ack) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
      end
    endcase

    // Jump target and write address both use A as it was before this commit.
    if (commit) begin
      if (dest[DEST_D]) dreg_d = alu_out;
      if (dest[DEST_A]) areg_d = alu_out;
      pc_d = jump ? areg_q[ADDR_W-1:0] : (pc_q + PC_ONE);
      if (dest[DEST_M]) begin
        waddr_d = areg_q[ADDR_W-1:0];
        wdata_d = alu_out;
        state_d = S_MWR;
      end else begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
    end

    ireq_d = (state_d == S_FETCH);
    dreq_d = (state_d == S_MRD) || (state_d == S_MWR);
    dwe_d  = (state_d == S_MWR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      areg_q   <= '0;
      dreg_q   <= '0;
      ir_q     <= '0;
      ireq_q   <= 1'b0;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      areg_q   <= areg_d;
      dreg_q   <= dreg_d;
      ir_q     <= ir_d;
      ireq_q   <= ireq_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      retire_q <= retire_d;
    end
  end

  // Write capture is pure data; it is only observed while MWR holds dmem_req.
  always_ff @(posedge clk) begin
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
  end

  assign imem_req   = ireq_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dreq_q;
  assign dmem_we    = dwe_q;
  assign dmem_addr  = (state_q == S_MWR) ? waddr_q : areg_q[ADDR_W-1:0];
  assign dmem_wdata = wdata_q;
  assign pc         = pc_q;
  assign a_reg      = areg_q;
  assign d_reg      = dreg_q;
  assign retire     = retire_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: a reference model queues expected fetches,
// memory accesses and retire states; memory responders and a retire monitor check them.
module tb_hack_cpu_mc;

  localparam int DW  = 16;
  localparam int AW  = 15;
  localparam int MSZ = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          imem_req, imem_valid, dmem_req, dmem_we, dmem_ack, retire;
  logic [AW-1:0] imem_addr, dmem_addr, pc;
  logic [DW-1:0] imem_rdata, dmem_wdata, dmem_rdata, a_reg, d_reg;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .retire(retire)
  );

  logic          rst24;
  logic          imem_req24, imem_valid24, dmem_req24, dmem_we24, dmem_ack24, retire24;
  logic [19:0]   imem_addr24, dmem_addr24, pc24;
  logic [23:0]   imem_rdata24, dmem_wdata24, dmem_rdata24, a_reg24, d_reg24;

  hack_cpu_mc #(.DATA_W(24), .ADDR_W(20)) dut24 (
    .clk(clk), .rst(rst24),
    .imem_req(imem_req24), .imem_addr(imem_addr24), .imem_valid(imem_valid24), .imem_rdata(imem_rdata24),
    .dmem_req(dmem_req24), .dmem_we(dmem_we24), .dmem_addr(dmem_addr24), .dmem_wdata(dmem_wdata24),
    .dmem_rdata(dmem_rdata24), .dmem_ack(dmem_ack24),
    .pc(pc24), .a_reg(a_reg24), .d_reg(d_reg24), .retire(retire24)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rcnt = 0;
  int excl_viol = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int a; int d; int pc; int lat;} ret_t;

  logic [DW-1:0] bmem [MSZ];
  logic [DW-1:0] mmem [MSZ];
  logic [DW-1:0] feed_q[$];
  int            fetch_q[$];
  int            fcyc_q[$];
  int            rd_q[$];
  wr_t           wr_q[$];
  ret_t          ret_q[$];

  int imem_wait = 0, rd_wait = 0, wr_wait = 0;
  int mA = 0, mD = 0, mPC = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] o;
    if (c[5]) x = 16'h0;
    if (c[4]) x = ~x;
    if (c[3]) y = 16'h0;
    if (c[2]) y = ~y;
    o = c[1] ? x + y : x & y;
    if (c[0]) o = ~o;
    return o;
  endfunction

  // Reference model: executes one instruction architecturally and queues expectations.
  task automatic issue(input logic [15:0] ins);
    logic [15:0] y, o;
    logic signed [15:0] s;
    int lat, oldA;
    bit jmp;
    feed_q.push_back(ins);
    fetch_q.push_back(mPC);
    lat = 2;
    if (!ins[15]) begin
      mA  = int'(ins & 16'h7FFF);
      mPC = (mPC + 1) % MSZ;
    end else begin
      oldA = mA;
      if (ins[12]) begin
        y = mmem[mA % MSZ];
        rd_q.push_back(mA % MSZ);
        lat += 1 + rd_wait;
      end else begin
        y = 16'(mA);
      end
      o = alu_ref(16'(mD), y, ins[11:6]);
      s = o;
      case (ins[2:0])
        3'd0: jmp = 0;
        3'd1: jmp = (s > 0);
        3'd2: jmp = (s == 0);
        3'd3: jmp = (s >= 0);
        3'd4: jmp = (s < 0);
        3'd5: jmp = (s != 0);
        3'd6: jmp = (s <= 0);
        default: jmp = 1;
      endcase
      if (ins[3]) begin
        wr_q.push_back('{oldA % MSZ, int'(o)});
        mmem[oldA % MSZ] = o;
        lat += 1 + wr_wait;
      end
      if (ins[4]) mD = int'(o);
      if (ins[5]) mA = int'(o);
      mPC = jmp ? (oldA % MSZ) : ((mPC + 1) % MSZ);
    end
    ret_q.push_back('{mA, mD, mPC, lat});
  endtask

  function automatic logic [15:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if (r[31]) return {3'b111, r[12:0]};
    return {1'b0, r[14:0]};
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((ret_q.size() > 0 || feed_q.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (ret_q.size() > 0 || feed_q.size() > 0) fail_evt("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  // Memory responder for the 16-bit core.
  initial begin
    int icnt, dcnt;
    logic prev_dreq, prev_dack, dbad, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    wr_t w;
    icnt = 0; dcnt = 0; prev_dreq = 0; prev_dack = 0; dbad = 0;
    s_we = 0; s_addr = '0; s_wd = '0;
    imem_valid = 0; imem_rdata = '0; dmem_ack = 0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req && dmem_req) excl_viol++;
      if (!rst) begin
        imem_valid = 0; dmem_ack = 0; icnt = 0; dcnt = 0; prev_dreq = 0; prev_dack = 0;
      end else begin
        if (imem_req) begin
          if (icnt >= imem_wait && feed_q.size() > 0) begin
            imem_valid = 1;
            imem_rdata = feed_q.pop_front();
            icnt = 0;
            if (fetch_q.size() == 0) fail_evt("fetch_unexpected");
            else chk("fetch_addr", 32'(imem_addr), 32'(fetch_q.pop_front()));
            fcyc_q.push_back(cyc);
          end else begin
            imem_valid = 0;
            imem_rdata = 16'($urandom);
            icnt++;
          end
        end else begin
          imem_valid = 1'($urandom);
          imem_rdata = 16'($urandom);
        end
        if (dmem_req) begin
          if (!prev_dreq || prev_dack) begin
            s_addr = dmem_addr; s_we = dmem_we; s_wd = dmem_wdata; dbad = 0;
          end else if (dmem_addr !== s_addr || dmem_we !== s_we || (s_we && dmem_wdata !== s_wd)) begin
            dbad = 1;
          end
          if (dcnt >= (dmem_we ? wr_wait : rd_wait)) begin
            dmem_ack = 1;
            dcnt = 0;
            chk("dmem_stable", 32'(dbad), 32'd0);
            if (dmem_we) begin
              if (wr_q.size() == 0) fail_evt("write_unexpected");
              else begin
                w = wr_q.pop_front();
                chk("wr_addr", 32'(dmem_addr), 32'(w.addr));
                chk("wr_data", 32'(dmem_wdata), 32'(w.data));
              end
              bmem[dmem_addr] = dmem_wdata;
            end else begin
              dmem_rdata = bmem[dmem_addr];
              if (rd_q.size() == 0) fail_evt("read_unexpected");
              else chk("rd_addr", 32'(dmem_addr), 32'(rd_q.pop_front()));
            end
          end else begin
            dmem_ack = 0;
            dmem_rdata = 16'($urandom);
            dcnt++;
          end
        end else begin
          dmem_ack = 1'($urandom);
          dmem_rdata = 16'($urandom);
          dcnt = 0;
        end
        prev_dreq = dmem_req;
        prev_dack = dmem_ack;
      end
    end
  end

  // Retire monitor.
  initial begin
    ret_t r;
    int f;
    forever begin
      @(negedge clk);
      if (rst && retire) begin
        rcnt++;
        if (ret_q.size() == 0 || fcyc_q.size() == 0) fail_evt("retire_unexpected");
        else begin
          r = ret_q.pop_front();
          f = fcyc_q.pop_front();
          chk("ret_a", 32'(a_reg), 32'(r.a));
          chk("ret_d", 32'(d_reg), 32'(r.d));
          chk("ret_pc", 32'(pc), 32'(r.pc));
          chk("ret_latency", 32'(cyc - f), 32'(r.lat));
        end
      end
    end
  end

  // Trivial zero-wait responder for the 24-bit core.
  initial begin
    imem_valid24 = 0; imem_rdata24 = '0; dmem_ack24 = 0; dmem_rdata24 = '0;
    forever begin
      @(negedge clk);
      imem_valid24 = imem_req24;
      imem_rdata24 = 24'h7FFFFF;
      dmem_ack24   = dmem_req24;
    end
  end

  initial begin
    int r0, pcb, n;
    logic [DW-1:0] pre, v;
    rst = 0;
    rst24 = 0;
    for (int i = 0; i < MSZ; i++) begin
      v = 16'($urandom);
      bmem[i] = v;
      mmem[i] = v;
    end
    repeat (3) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_dmem_we", 32'(dmem_we), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_a", 32'(a_reg), 0);
    chk("rst_d", 32'(d_reg), 0);
    #2 rst = 1;

    // @5 ; D=A
    r0 = rcnt;
    issue(16'h0005);
    issue(16'hEC10);
    wait_idle(200);
    chk("t1_d", 32'(d_reg), 5);
    chk("t1_pc", 32'(pc), 2);
    chk("t1_retires", 32'(rcnt - r0), 2);

    // M=D+M at A=100 with read and write wait states
    bmem[100] = 16'd7;
    mmem[100] = 16'd7;
    rd_wait = 2;
    wr_wait = 1;
    issue(16'h0064);
    issue(16'hF088);
    wait_idle(200);
    chk("t2_mem100", 32'(bmem[100]), 12);
    rd_wait = 0;
    wr_wait = 0;

    // D=0 ; @10 ; D;JEQ taken
    issue(16'hEA90);
    issue(16'h000A);
    issue(16'hE302);
    wait_idle(200);
    chk("jeq_pc", 32'(pc), 10);
    // D=-1 ; @50 ; D;JGT not taken ; 0;JMP always
    issue(16'hEE90);
    issue(16'h0032);
    pcb = mPC;
    issue(16'hE301);
    wait_idle(200);
    chk("jgt_pc", 32'(pc), 32'(pcb + 1));
    issue(16'hEA87);
    wait_idle(200);
    chk("jmp_pc", 32'(pc), 50);

    // AM=M-1 at A=20, mem[20]=3
    bmem[20] = 16'd3;
    mmem[20] = 16'd3;
    issue(16'h0014);
    issue(16'hFCA8);
    wait_idle(200);
    chk("t4_a", 32'(a_reg), 2);
    chk("t4_mem20", 32'(bmem[20]), 2);

    // PC wrap from 0x7FFF
    issue(16'h7FFF);
    issue(16'hEA87);
    wait_idle(200);
    chk("wrap_pre", 32'(pc), 32'h7FFF);
    issue(16'h0003);
    wait_idle(200);
    chk("wrap_pc", 32'(pc), 0);

    // Randomized batches with varied wait states
    for (int b = 0; b < 10; b++) begin
      imem_wait = $urandom_range(0, 2);
      rd_wait = $urandom_range(0, 3);
      wr_wait = $urandom_range(0, 3);
      for (int k = 0; k < 20; k++) issue(rand_instr());
      wait_idle(3000);
    end

    // Reset while MWR is waiting: access abandoned, no write
    imem_wait = 0;
    rd_wait = 0;
    wr_wait = 8;
    issue(16'h001E);
    wait_idle(200);
    pre = bmem[30];
    issue(16'hE308);
    n = 0;
    while (!(dmem_req && dmem_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(dmem_req && dmem_we)) fail_evt("mwr_timeout");
    repeat (2) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("abort_dmem_req", 32'(dmem_req), 0);
    chk("abort_pc", 32'(pc), 0);
    chk("abort_a", 32'(a_reg), 0);
    chk("abort_wr_pending", 32'(wr_q.size()), 1);
    repeat (3) @(negedge clk);
    chk("abort_nowrite", 32'(bmem[30]), 32'(pre));
    feed_q.delete(); fetch_q.delete(); fcyc_q.delete();
    rd_q.delete(); wr_q.delete(); ret_q.delete();
    mA = 0; mD = 0; mPC = 0;
    mmem[30] = bmem[30];
    wr_wait = 0;
    #2 rst = 1;
    issue(16'h0009);
    wait_idle(200);
    chk("post_rst_a", 32'(a_reg), 9);
    chk("post_rst_pc", 32'(pc), 1);

    // 24-bit core loads a full-width A-instruction
    @(negedge clk);
    #2 rst24 = 1;
    n = 0;
    while (!retire24 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!retire24) fail_evt("w24_timeout");
    chk("w24_a", 32'(a_reg24), 32'h7FFFFF);
    chk("w24_pc", 32'(pc24), 1);

    chk("req_exclusive", 32'(excl_viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hack_cpu_mc.md
HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning datapath, instruction and register width (legal values 16..32).
REQ-002 SHALL have parameter ADDR_W, default 15, meaning PC and memory address width (legal values 1..DATA_W-1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  meaning instruction fetch request.
REQ-006 SHALL have port imem_addr  output  ADDR_W  meaning fetch address, always equal to pc.
REQ-007 SHALL have port imem_valid  input  1  meaning imem_rdata is valid this cycle.
REQ-008 SHALL have port imem_rdata  input  DATA_W  meaning fetched instruction.
REQ-009 SHALL have port dmem_req  output  1  meaning data memory access request.
REQ-010 SHALL have port dmem_we  output  1  meaning 1 = write, 0 = read; valid only while dmem_req is high.
REQ-011 SHALL have port dmem_addr  output  ADDR_W  meaning data address.
REQ-012 SHALL have port dmem_wdata  output  DATA_W  meaning write data.
REQ-013 SHALL have port dmem_rdata  input  DATA_W  meaning read data; valid while dmem_ack is high.
REQ-014 SHALL have port dmem_ack  input  1  meaning the access completes this cycle.
REQ-015 SHALL have port pc  output  ADDR_W  meaning program counter.
REQ-016 SHALL have port a_reg / d_reg  output  DATA_W each  meaning debug views of the A and D registers.
REQ-017 SHALL have port retire  output  1  meaning one-cycle pulse when an instruction completes.

Function
REQ-018 SHALL decode instr[DATA_W-1]=0 as an A-instruction and 1 as a C-instruction, with C fields a=instr[12], zx..no=instr[11:6], d=instr[5:3] (A,D,M) and j=instr[2:0].
REQ-019 SHALL execute an A-instruction by loading A with the instruction with bit DATA_W-1 cleared.
REQ-020 SHALL implement a state machine with states FETCH, EXEC, MRD and MWR.
REQ-021 SHALL hold imem_req high in FETCH; when imem_valid is sampled high, it latches the IR and moves to EXEC, otherwise it stays in FETCH.
REQ-022 In EXEC, an A-instruction or a C-instruction with a=0 SHALL compute and commit, while a C-instruction with a=1 SHALL move to MRD.
REQ-023 MRD SHALL hold dmem_req=1, dmem_we=0 and dmem_addr=A[ADDR_W-1:0] until dmem_ack, then compute using dmem_rdata as Y and commit.
REQ-024 Commit SHALL, in one edge, write the ALU result to D if d[1] and to A if d[2], and update the PC.
REQ-025 If d[0] is set, commit SHALL capture the write address (A before the commit) and the ALU result, then go to MWR; otherwise it goes to FETCH.
REQ-026 MWR SHALL hold dmem_req=1, dmem_we=1 and the captured addr/wdata stable until dmem_ack, then go to FETCH.
REQ-027 The ALU SHALL follow standard Hack semantics at DATA_W bits, with zr = (out==0) and ng = out[DATA_W-1].
REQ-028 The jump test SHALL be jump = (j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr); j=000 never jumps and j=111 always jumps.
REQ-029 The PC update SHALL be PC <= A[ADDR_W-1:0] (the old A) on jump, else PC+1, wrapping modulo 2^ADDR_W; an A-instruction always increments.
REQ-030 retire SHALL pulse on the cycle the machine re-enters FETCH after an instruction completes.
REQ-031 Minimum latency SHALL be 2 cycles for an A-instruction or a=0 C-instruction with zero wait states, 3 cycles with an M read or M write, and 4 cycles with both.
REQ-032 dmem_req and imem_req SHALL never both be high in the same cycle.
REQ-033 A request SHALL never be withdrawn or changed before its ack or valid.
REQ-034 imem_valid outside FETCH and dmem_ack outside MRD/MWR SHALL be ignored.

Reset
REQ-035 While rst=0, the block SHALL asynchronously force state=FETCH, pc=0, A=0, D=0, IR=0, and imem_req, dmem_req, dmem_we and retire to 0.
REQ-036 A reset asserted mid-MRD or mid-MWR SHALL abandon the access with no register update.
REQ-037 After rst deasserts, the first rising edge SHALL begin a fetch at address 0.

Structure
REQ-038 A shared package hack_pkg SHALL hold the state enum, the C-field bit positions and the jump-code constants.
REQ-039 The ALU SHALL be one sub-module, hack_alu, parameterised by DATA_W and purely combinational.
REQ-040 The top level SHALL hold the FSM, registers, jump logic and memory handshakes.

Verification
REQ-041 The bench SHALL cover: reset, then @5 (0x0005) then D=A (0xEC10) with zero wait states -> D=5, pc=2 and two retire pulses, 2 cycles each.
REQ-042 The bench SHALL cover: D=5, A=100, mem[100]=7, then M=D+M (0xF088) with 3-cycle read and 2-cycle write acks -> write addr 100, data 12, and dmem signals stable throughout the waits.
REQ-043 The bench SHALL cover: D=0 with j=JEQ taken to A=10, and D=-1 with JGT not taken -> pc=10 and pc=prev+1 respectively; with j=111, pc=A regardless of flags.
REQ-044 The bench SHALL cover: AM=M-1 at A=20 with mem[20]=3 -> write to address 20 (the old A) with data 2, then A=2.
REQ-045 The bench SHALL cover: pc=2^ADDR_W-1 with a non-jump instruction -> pc wraps to 0; and DATA_W=24 with ADDR_W=20 -> A-instruction 0x7FFFFF loads 0x7FFFFF.
REQ-046 The bench SHALL cover: rst dropped while MWR is waiting -> dmem_req falls immediately, pc=0, and no write occurs.
